tournament_branch_predictor: RTL and testbench



---
 rtl/tournament_branch_predictor.sv | 169 ++++++++++++++++
 tb/tb_tournament_branch_predictor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tournament_branch_predictor.sv
// Tournament conditional-branch predictor: local-history and gshare components arbitrated by a
// choice table, with a speculative global history and commit-time training.
module tournament_branch_predictor #(
    parameter int VLEN            = 64,
    parameter int PcLsb           = 1,
    parameter int LhtIndexBits    = 7,
    parameter int LocalHistBits   = 10,
    parameter int GlobalIndexBits = 12,
    parameter int ChoiceIndexBits = 12,
    parameter int LocalCtrBits    = 3,
    parameter int GlobalCtrBits   = 2,
    parameter int ChoiceCtrBits   = 2,
    parameter int MetaW           = GlobalIndexBits + LocalHistBits + 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             init_done_o,
    input  logic             lookup_valid_i,
    input  logic [VLEN-1:0]  lookup_pc_i,
    output logic             pred_taken_o,
    output logic [MetaW-1:0] pred_meta_o,
    input  logic             update_valid_i,
    input  logic [VLEN-1:0]  update_pc_i,
    input  logic             update_taken_i,
    input  logic             update_mispredict_i,
    input  logic [MetaW-1:0] update_meta_i
);

    localparam int MaxIdxA = (LhtIndexBits > LocalHistBits) ? LhtIndexBits : LocalHistBits;
    localparam int MaxIdxB = (GlobalIndexBits > ChoiceIndexBits) ? GlobalIndexBits : ChoiceIndexBits;
    localparam int MaxIdx  = (MaxIdxA > MaxIdxB) ? MaxIdxA : MaxIdxB;
    localparam logic [MaxIdx-1:0] IdxLast = '1;

    localparam int unsigned LctrMax = (1 << LocalCtrBits) - 1;
    localparam int unsigned GctrMax = (1 << GlobalCtrBits) - 1;
    localparam int unsigned CctrMax = (1 << ChoiceCtrBits) - 1;

    // Weakly not-taken / weakly prefer-local: MSB clear, all lower bits set.
    localparam logic [LocalCtrBits-1:0]  LctrInit = {1'b0, {(LocalCtrBits-1){1'b1}}};
    localparam logic [GlobalCtrBits-1:0] GctrInit = {1'b0, {(GlobalCtrBits-1){1'b1}}};
    localparam logic [ChoiceCtrBits-1:0] CctrInit = {1'b0, {(ChoiceCtrBits-1){1'b1}}};

    typedef enum logic {INIT, READY} state_t;

    state_t                     state;
    logic [MaxIdx-1:0]          idx;
    logic [GlobalIndexBits-1:0] ghr;
    logic                       ready;

    logic [LocalHistBits-1:0] lht  [2**LhtIndexBits];
    logic [LocalCtrBits-1:0]  lctr [2**LocalHistBits];
    logic [GlobalCtrBits-1:0] gctr [2**GlobalIndexBits];
    logic [ChoiceCtrBits-1:0] cctr [2**ChoiceIndexBits];

    function automatic int unsigned sat_step(input int unsigned value, input logic up,
                                             input int unsigned max_value);
        if (up) begin
            return (value == max_value) ? value : value + 1;
        end else begin
            return (value == 0) ? value : value - 1;
        end
    endfunction

    assign ready = (state == READY);

    logic [LhtIndexBits-1:0]    look_pcl;
    logic [LocalHistBits-1:0]   look_lh;
    logic [GlobalIndexBits-1:0] look_gidx;
    logic                       look_local;
    logic                       look_global;
    logic                       look_choice;
    logic                       look_pred;

    assign look_pcl    = lookup_pc_i[PcLsb +: LhtIndexBits];
    assign look_lh     = lht[look_pcl];
    assign look_gidx   = lookup_pc_i[PcLsb +: GlobalIndexBits] ^ ghr;
    assign look_local  = lctr[look_lh][LocalCtrBits-1];
    assign look_global = gctr[look_gidx][GlobalCtrBits-1];
    assign look_choice = cctr[ghr[ChoiceIndexBits-1:0]][ChoiceCtrBits-1];
    assign look_pred   = look_choice ? look_global : look_local;

    assign pred_taken_o = ready & look_pred;
    assign pred_meta_o  = ready ? {ghr, look_lh, look_local, look_global} : '0;

    logic [GlobalIndexBits-1:0] upd_ghr;
    logic [LocalHistBits-1:0]   upd_lh;
    logic                       upd_local;
    logic                       upd_global;
    logic [LhtIndexBits-1:0]    upd_pcl;
    logic [GlobalIndexBits-1:0] upd_gidx;
    logic [ChoiceIndexBits-1:0] upd_cidx;
    logic                       upd_en;

    assign upd_ghr    = update_meta_i[LocalHistBits+2 +: GlobalIndexBits];
    assign upd_lh     = update_meta_i[2 +: LocalHistBits];
    assign upd_local  = update_meta_i[1];
    assign upd_global = update_meta_i[0];
    assign upd_pcl    = update_pc_i[PcLsb +: LhtIndexBits];
    assign upd_gidx   = update_pc_i[PcLsb +: GlobalIndexBits] ^ upd_ghr;
    assign upd_cidx   = upd_ghr[ChoiceIndexBits-1:0];
    assign upd_en     = ready & update_valid_i & ~rst_i;

    // PC bits above the index windows do not participate in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i, update_pc_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= INIT;
            idx         <= '0;
            init_done_o <= 1'b0;
            ghr         <= '0;
        end else begin
            case (state)
                INIT: begin
                    idx <= idx + MaxIdx'(1);
                    if (idx == IdxLast) begin
                        state       <= READY;
                        init_done_o <= 1'b1;
                    end
                end
                READY: begin
                    // A mispredict restore supersedes the speculative shift of a concurrent lookup.
                    if (update_valid_i && update_mispredict_i) begin
                        ghr <= {upd_ghr[GlobalIndexBits-2:0], update_taken_i};
                    end else if (lookup_valid_i) begin
                        ghr <= {ghr[GlobalIndexBits-2:0], look_pred};
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!ready) begin
            lht[idx[LhtIndexBits-1:0]] <= '0;
        end else if (upd_en) begin
            lht[upd_pcl] <= {lht[upd_pcl][LocalHistBits-2:0], update_taken_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!ready) begin
            lctr[idx[LocalHistBits-1:0]] <= LctrInit;
        end else if (upd_en) begin
            lctr[upd_lh] <= LocalCtrBits'(sat_step(32'(lctr[upd_lh]), update_taken_i, LctrMax));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!ready) begin
            gctr[idx[GlobalIndexBits-1:0]] <= GctrInit;
        end else if (upd_en) begin
            gctr[upd_gidx] <= GlobalCtrBits'(sat_step(32'(gctr[upd_gidx]), update_taken_i, GctrMax));
        end
    end

    // The chooser only learns when the two components disagreed.
    always_ff @(posedge clk_i) begin
        if (!ready) begin
            cctr[idx[ChoiceIndexBits-1:0]] <= CctrInit;
        end else if (upd_en && (upd_local != upd_global)) begin
            cctr[upd_cidx] <= ChoiceCtrBits'(sat_step(32'(cctr[upd_cidx]),
                                                     upd_global == update_taken_i, CctrMax));
        end
    end

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Directed bench for the tournament predictor: init sweep, loop training, history restore,
// counter saturation, chooser behaviour and mid-run reset.
module tb_tournament_branch_predictor;

    localparam logic [63:0] PcLoop = 64'h0000_0000_8000_0010;
    localparam logic [63:0] PcAlt  = 64'h0000_0000_0000_0100;
    localparam logic [63:0] PcLsat = 64'h0000_0000_0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        lookup_valid;
    logic [63:0] lookup_pc;
    logic        pred_taken;
    logic [23:0] pred_meta;
    logic        update_valid;
    logic [63:0] update_pc;
    logic        update_taken;
    logic        update_mispredict;
    logic [23:0] update_meta;

    int checks = 0;
    int errors = 0;

    tournament_branch_predictor dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .init_done_o         (init_done),
        .lookup_valid_i      (lookup_valid),
        .lookup_pc_i         (lookup_pc),
        .pred_taken_o        (pred_taken),
        .pred_meta_o         (pred_meta),
        .update_valid_i      (update_valid),
        .update_pc_i         (update_pc),
        .update_taken_i      (update_taken),
        .update_mispredict_i (update_mispredict),
        .update_meta_i       (update_meta)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid      = 1'b0;
        update_valid      = 1'b0;
        update_taken      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    function automatic logic [23:0] mk_meta(input logic [11:0] g, input logic [9:0] lh,
                                            input logic lp, input logic gp);
        return {g, lh, lp, gp};
    endfunction

    task automatic send_update(input logic [63:0] pc, input logic taken, input logic mispredict,
                               input logic [23:0] meta);
        lookup_valid      = 1'b0;
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_mispredict = mispredict;
        update_meta       = meta;
        step();
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    // Called right after the reset edge: 4096 quiet samples, then ready.
    task automatic wait_init(input string tag);
        int early;
        early = 0;
        for (int i = 0; i < 4096; i++) begin
            #1;
            if (init_done !== 1'b0 || pred_taken !== 1'b0 || pred_meta !== 24'h0) early++;
            step();
        end
        check({tag, "_quiet"}, early, 0);
        check({tag, "_done"}, init_done, 1);
    endtask

    initial begin
        logic        p;
        logic [23:0] m;
        int          mispredicts;

        rst = 1'b1;
        idle();
        lookup_pc   = '0;
        update_pc   = '0;
        update_meta = '0;
        step();
        rst = 1'b0;
        check("reset_done", init_done, 0);

        lookup_valid = 1'b1;
        lookup_pc    = PcLoop;
        wait_init("init");
        #1;
        check("first_pred", pred_taken, 0);
        check("first_meta", pred_meta, 24'h0);

        mispredicts = 0;
        for (int k = 1; k <= 16; k++) begin
            lookup_valid = 1'b1;
            lookup_pc    = PcLoop;
            #1;
            p = pred_taken;
            m = pred_meta;
            check($sformatf("loop_pred_%0d", k), p, (k <= 11) ? 64'd0 : 64'd1);
            if (k == 5) check("loop_meta_5", m, 24'h00F03C);
            step();
            if (p != 1'b1) mispredicts++;
            send_update(PcLoop, 1'b1, p != 1'b1, m);
        end
        check("loop_mispredicts", mispredicts, 11);
        #1;
        check("loop_final_pred", pred_taken, 1);
        check("loop_final_meta", pred_meta, 24'hFFFFFF);

        lookup_valid = 1'b1;
        #1;
        p = pred_taken;
        m = pred_meta;
        check("retrain_pred", p, 1);
        step();
        send_update(PcLoop, 1'b1, 1'b0, m);
        rst          = 1'b1;
        lookup_valid = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_done", init_done, 0);
        wait_init("reinit");
        lookup_valid = 1'b0;
        #1;
        check("reinit_pred", pred_taken, 0);
        check("reinit_meta", pred_meta, 24'h0);

        lookup_valid      = 1'b1;
        lookup_pc         = PcLoop;
        update_valid      = 1'b1;
        update_pc         = PcAlt;
        update_taken      = 1'b1;
        update_mispredict = 1'b1;
        update_meta       = mk_meta(12'h0A5, 10'h155, 1'b0, 1'b0);
        #1;
        check("collide_pred", pred_taken, 0);
        step();
        idle();
        #1;
        check("collide_ghr", pred_meta[23:12], 12'h14B);
        check("collide_meta", pred_meta, 24'h14B000);

        for (int i = 0; i < 10; i++) send_update(PcLsat, 1'b1, 1'b0, mk_meta(12'h0, 10'h0, 1'b0, 1'b0));
        #1;
        check("lsat_up_pred", pred_taken, 1);
        check("lsat_ghr_kept", pred_meta[23:12], 12'h14B);
        for (int i = 0; i < 3; i++) send_update(PcLsat, 1'b0, 1'b0, mk_meta(12'h0, 10'h0, 1'b0, 1'b0));
        #1;
        check("lsat_down3_pred", pred_taken, 1);
        send_update(PcLsat, 1'b0, 1'b0, mk_meta(12'h0, 10'h0, 1'b0, 1'b0));
        #1;
        check("lsat_down4_pred", pred_taken, 0);

        for (int i = 0; i < 5; i++) send_update(PcLoop, 1'b0, 1'b0, mk_meta(12'h14B, 10'h200, 1'b0, 1'b0));
        #1;
        check("gsat_5_gp", pred_meta[0], 0);
        send_update(PcLoop, 1'b0, 1'b0, mk_meta(12'h14B, 10'h200, 1'b0, 1'b0));
        #1;
        check("gsat_6_gp", pred_meta[0], 0);
        for (int i = 0; i < 2; i++) send_update(PcLoop, 1'b1, 1'b0, mk_meta(12'h14B, 10'h200, 1'b0, 1'b0));
        #1;
        check("gsat_up_gp", pred_meta[0], 1);
        check("gsat_up_meta", pred_meta, 24'h14B00D);
        check("gsat_up_pred", pred_taken, 0);

        send_update(PcAlt, 1'b1, 1'b0, mk_meta(12'h14B, 10'h200, 1'b1, 1'b0));
        #1;
        check("choice_local_right", pred_taken, 0);
        send_update(PcAlt, 1'b1, 1'b0, mk_meta(12'h14B, 10'h200, 1'b1, 1'b1));
        #1;
        check("choice_agree", pred_taken, 0);
        send_update(PcAlt, 1'b1, 1'b0, mk_meta(12'h14B, 10'h200, 1'b0, 1'b1));
        #1;
        check("choice_global_1", pred_taken, 0);
        update_valid = 1'b1;
        update_pc    = PcAlt;
        update_taken = 1'b1;
        update_meta  = mk_meta(12'h14B, 10'h200, 1'b0, 1'b1);
        #1;
        check("choice_rbw", pred_taken, 0);
        step();
        update_valid = 1'b0;
        #1;
        check("choice_global_2", pred_taken, 1);
        send_update(PcAlt, 1'b1, 1'b0, mk_meta(12'h14B, 10'h200, 1'b0, 1'b1));
        #1;
        check("choice_global_3", pred_taken, 1);
        send_update(PcAlt, 1'b1, 1'b0, mk_meta(12'h14B, 10'h200, 1'b1, 1'b0));
        #1;
        check("choice_back_to_2", pred_taken, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
